gate_clock_ctrl: RTL and testbench
==================================

Name: gate_clock_ctrl

Overview:
- Controls NUM_DOMAINS instances of gateClockCell in the ETROC2 readout, one per clock domain (e.g. circular buffers, L1 buffers, serializer front-end).
- Drives each cell's gate input and reports when each gated clock is usable.
- Turns a domain's clock off after a programmable run of idle cycles.
- Wakes domains on request, one at a time, using round-robin arbitration so that simultaneous wake-ups cannot cause a current step.

Parameters:
- NUM_DOMAINS, 4, number of gated domains (≥2).
- WAKE_CYC, 2, cycles a domain stays in WAKE before ready asserts (≥1).
- IDLE_CYC, 16, consecutive idle cycles before a domain is gated off (≥1).

Ports:
- clk  input  1  free-running readout clock; same clock feeds every gateClockCell.
- reset  input  1  asynchronous, active-high reset.
- enableGate  input  1  global gating enable, wired in parallel to every cell; 0 means all clocks forced on.
- req  input  NUM_DOMAINS  per-domain work pending.
- busy  input  NUM_DOMAINS  per-domain activity flag, sampled from the gated domain.
- gate  output  NUM_DOMAINS  to gateClockCell.gate; 1 means clock passes.
- ready  output  NUM_DOMAINS  gated clock running and settled.
- wakeActive  output  1  some domain is currently in WAKE.

Behaviour:
- Reset (asynchronous, effective immediately):
  - all domain states = OFF, idle and wake counters = 0.
  - gate = 0, ready = 0, wakeActive = 0.
  - round-robin pointer = NUM_DOMAINS-1, so domain 0 has top priority first.
- Per-domain states: OFF, WAKE, ON. All outputs decode registered state only:
  - gate[i] = (state != OFF).
  - ready[i] = (state == ON).
  - wakeActive = OR over all domains of (state == WAKE).
- OFF -> WAKE:
  - Arbitration runs in a cycle where no domain is in WAKE.
  - Candidates are domains in OFF with req = 1.
  - The winner is the first candidate found after the pointer, searching circularly.
  - The winner enters WAKE on the next edge; the pointer updates to the winner.
- WAKE timing:
  - WAKE lasts exactly WAKE_CYC cycles, then the domain goes to ON.
  - Example: req sampled at cycle k gives WAKE at k+1 .. k+WAKE_CYC and ON (ready = 1) at k+WAKE_CYC+1.
  - The next grant can happen at the earliest at cycle k+WAKE_CYC+1, so wakes are spaced WAKE_CYC+1 cycles apart.
- A req drop during WAKE does not abort the wake. WAKE completes and the domain enters ON with its idle counter at 0.
- ON idle counting:
  - If req|busy, the idle counter clears.
  - Otherwise the counter increments, saturating at IDLE_CYC.
  - The domain returns to OFF on the edge after IDLE_CYC consecutive idle cycles; gate and ready fall together.
  - If req or busy is high in the cycle the counter would expire, the domain stays ON and the counter clears (activity wins).
- enableGate = 0:
  - On the next edge, every domain is forced to ON, idle counters clear and arbitration is suspended.
  - Any domain in WAKE is forced to ON.
  - gate and ready are therefore all 1 from that edge onward.
- enableGate 0 -> 1: domains start in ON with counters at 0, and normal idle gating resumes.
- Counter widths: $clog2(WAKE_CYC+1) and $clog2(IDLE_CYC+1). No wrap-around is permitted; the idle counter saturates.
- A domain in OFF with req = 0 never wakes; busy alone cannot wake it, because busy is generated by the gated domain.
- Reset asserted mid-WAKE or mid-ON: all outputs drop to 0 immediately, and no partial grant persists after reset is released.

Decomposition:
- Package gate_clock_ctrl_pkg contains:
  - the state typedef {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2}.
  - helper function for counter widths.
- Sub-module gate_clock_domain_fsm, one instance per domain:
  - holds that domain's state, wake counter and idle counter.
  - inputs: grant, req, busy, enableGate.
  - outputs: state, gate, ready.
- Top level contains the round-robin arbiter and pointer register, and generates the domain instances.

Test Plan:
1. enableGate = 1, req[0] pulsed at cycle 5 with busy = 0 → gate[0] = 1 at 6; ready[0] = 1 at 8; gate[0] = ready[0] = 0 at 24 (16 idle cycles).
2. req[3:0] = 4'hF held from cycle 5 after reset → gate rises for domains 0, 1, 2, 3 at cycles 6, 9, 12, 15; ready at 8, 11, 14, 17; wakeActive never covers two domains.
3. Pointer fairness: domain 1 granted last, then req[0] and req[3] rise together → domain 3 wins first; domain 0 is granted WAKE_CYC+1 cycles later.
4. Domain 2 in ON, idle for 15 cycles, busy[2] = 1 in the 16th cycle → stays ON, counter clears; it gates off only after 16 fresh idle cycles.
5. enableGate driven 0 while domain 1 in WAKE and the others OFF → next edge gate = ready = 4'hF; enableGate back to 1 with no req/busy → all gate = 0 exactly 16 cycles later.
6. reset asserted mid-WAKE of domain 0 → gate, ready and wakeActive fall without a clock edge; after release, req[1] alone → domain 1 granted, and the pointer starts from its reset value.

Source files
------------

// File: rtl/gate_clock_ctrl_pkg.sv
// Shared types and helpers for the gated-clock domain controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gate_clock_ctrl_pkg;

  // Per-domain clock state; gate and ready are decoded directly from it.
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2
  } dom_state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gate_clock_domain_fsm.sv
// One gated clock domain: OFF -> WAKE (WAKE_CYC cycles) -> ON -> OFF after IDLE_CYC idle cycles.
// Latency: grant seen at cycle k gives gate at k+1 and ready at k+WAKE_CYC+1.
// Backpressure: none; req/busy activity holds the domain ON, enableGate=0 forces it ON.
module gate_clock_domain_fsm
  import gate_clock_ctrl_pkg::*;
#(
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enableGate,
  input  logic       grant,
  input  logic       req,
  input  logic       busy,
  output dom_state_t state,
  output logic       gate,
  output logic       ready
);

  localparam int WW = cnt_width(WAKE_CYC);
  localparam int IW = cnt_width(IDLE_CYC);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

  dom_state_t    state_q, state_d;
  logic [WW-1:0] wake_cnt_q, wake_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  // Next-state: global override first, then wake timing and idle expiry.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    if (!enableGate) begin
      // Gating disabled: clock forced on, any wake in progress is finished immediately.
      state_d    = ON;
      wake_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        OFF: begin
          wake_cnt_d = '0;
          idle_cnt_d = '0;
          if (grant) state_d = WAKE;
        end
        WAKE: begin
          // A dropped req does not abort the wake; it simply completes.
          if (wake_cnt_q == WAKE_LAST) begin
            state_d    = ON;
            wake_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            wake_cnt_d = wake_cnt_q + WW'(1);
          end
        end
        ON: begin
          // Activity in the expiring cycle wins over gating off.
          if (req || busy) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_d    = OFF;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
        default: begin
          state_d    = OFF;
          wake_cnt_d = '0;
          idle_cnt_d = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OFF;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign state = state_q;
  assign gate  = (state_q != OFF);
  assign ready = (state_q == ON);

endmodule

// File: rtl/gate_clock_ctrl.sv
// Gate controller for NUM_DOMAINS gateClockCell instances with round-robin, one-at-a-time wake-up.
// Latency: req at cycle k -> gate at k+1, ready at k+WAKE_CYC+1; successive wakes WAKE_CYC+1 apart.
// Backpressure: a pending req waits while any domain is in WAKE or while gating is disabled.
module gate_clock_ctrl
  import gate_clock_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int WAKE_CYC    = 2,
  parameter int IDLE_CYC    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enableGate,
  input  logic [NUM_DOMAINS-1:0] req,
  input  logic [NUM_DOMAINS-1:0] busy,
  output logic [NUM_DOMAINS-1:0] gate,
  output logic [NUM_DOMAINS-1:0] ready,
  output logic                   wakeActive
);

  localparam int PW = $clog2(NUM_DOMAINS);

  dom_state_t             dom_state [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] in_wake;
  logic [NUM_DOMAINS-1:0] cand;
  logic [NUM_DOMAINS-1:0] grant;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   arb_found;
  int                     arb_idx;

  // Decode registered domain states into wake flags and wake candidates.
  always_comb begin
    in_wake = '0;
    cand    = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      in_wake[i] = (dom_state[i] == WAKE);
      cand[i]    = req[i] && (dom_state[i] == OFF);
    end
  end

  assign wakeActive = |in_wake;

  // Round-robin: first OFF requester after the last winner, only while nobody is waking.
  always_comb begin
    grant     = '0;
    ptr_d     = ptr_q;
    arb_found = 1'b0;
    arb_idx   = 0;
    if (enableGate && !wakeActive) begin
      for (int k = 1; k <= NUM_DOMAINS; k++) begin
        arb_idx = (int'(ptr_q) + k) % NUM_DOMAINS;
        if (!arb_found && cand[arb_idx]) begin
          arb_found      = 1'b1;
          grant[arb_idx] = 1'b1;
          ptr_d          = PW'(arb_idx);
        end
      end
    end
  end

  // Pointer resets to the last domain so domain 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= PW'(NUM_DOMAINS - 1);
    else       ptr_q <= ptr_d;
  end

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    gate_clock_domain_fsm #(
      .WAKE_CYC (WAKE_CYC),
      .IDLE_CYC (IDLE_CYC)
    ) u_dom (
      .clk        (clk),
      .reset      (reset),
      .enableGate (enableGate),
      .grant      (grant[g]),
      .req        (req[g]),
      .busy       (busy[g]),
      .state      (dom_state[g]),
      .gate       (gate[g]),
      .ready      (ready[g])
    );
  end

endmodule

// File: tb/tb_gate_clock_ctrl.sv
// Directed bench for gate_clock_ctrl with hand-computed expectations (WAKE_CYC=2, IDLE_CYC=16).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_gate_clock_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enableGate = 1'b1;
  logic [3:0] req = 4'h0;
  logic [3:0] busy = 4'h0;
  logic [3:0] gate;
  logic [3:0] ready;
  logic       wakeActive;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] rr_gate  [12] = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
  logic [3:0] rr_ready [12] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'hF};
  logic       rr_wake  [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  gate_clock_ctrl #(
    .NUM_DOMAINS (4),
    .WAKE_CYC    (2),
    .IDLE_CYC    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enableGate (enableGate),
    .req        (req),
    .busy       (busy),
    .gate       (gate),
    .ready      (ready),
    .wakeActive (wakeActive)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enableGate = 1'b1;
    req        = 4'h0;
    busy       = 4'h0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req   = 4'hF;
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({gate, ready, wakeActive} !== 9'h0) begin
      tests_failed++;
      $display("FAIL reset_hold: gate=%h ready=%h wake=%b, want all 0", gate, ready, wakeActive);
    end
    req   = 4'h0;
    reset = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({gate, ready, wakeActive} !== 9'h0) begin
      tests_failed++;
      $display("FAIL reset_idle: gate=%h ready=%h wake=%b, want all 0", gate, ready, wakeActive);
    end
    busy = 4'hF;
    repeat (4) tick();
    tests_run++;
    if (gate !== 4'h0) begin
      tests_failed++;
      $display("FAIL busy_no_wake: gate=%h, want 0", gate);
    end
    busy = 4'h0;
  endtask

  task automatic test_single_wake();
    apply_reset();
    req = 4'h1;
    tick();
    req = 4'h0;
    tests_run++;
    if (gate !== 4'h1 || ready !== 4'h0 || wakeActive !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: gate=%h ready=%h wake=%b, want 1/0/1", gate, ready, wakeActive);
    end
    tick();
    tests_run++;
    if (gate !== 4'h1 || ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL single_wake2: gate=%h ready=%h, want 1/0", gate, ready);
    end
    tick();
    tests_run++;
    if (gate !== 4'h1 || ready !== 4'h1 || wakeActive !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ready: gate=%h ready=%h wake=%b, want 1/1/0", gate, ready, wakeActive);
    end
    repeat (15) tick();
    tests_run++;
    if (gate !== 4'h1 || ready !== 4'h1) begin
      tests_failed++;
      $display("FAIL single_idle15: gate=%h ready=%h, want 1/1", gate, ready);
    end
    tick();
    tests_run++;
    if (gate !== 4'h0 || ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL single_off16: gate=%h ready=%h, want 0/0", gate, ready);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req = 4'hF;
    for (int t = 0; t < 12; t++) begin
      tick();
      tests_run++;
      if (gate !== rr_gate[t] || ready !== rr_ready[t] || wakeActive !== rr_wake[t]) begin
        tests_failed++;
        $display("FAIL rr_step%0d: gate=%h ready=%h wake=%b, want %h/%h/%b",
                 t + 1, gate, ready, wakeActive, rr_gate[t], rr_ready[t], rr_wake[t]);
      end
    end
    req = 4'h0;
  endtask

  task automatic test_fairness();
    apply_reset();
    req  = 4'h2;
    busy = 4'h2;
    tick();
    req = 4'h0;
    tests_run++;
    if (gate !== 4'h2) begin
      tests_failed++;
      $display("FAIL fair_d1: gate=%h, want 2", gate);
    end
    tick();
    tick();
    req = 4'h9;
    tick();
    tests_run++;
    if (gate !== 4'hA) begin
      tests_failed++;
      $display("FAIL fair_d3_first: gate=%h, want a", gate);
    end
    tick();
    tick();
    tests_run++;
    if (gate !== 4'hA || ready !== 4'hA) begin
      tests_failed++;
      $display("FAIL fair_d0_wait: gate=%h ready=%h, want a/a", gate, ready);
    end
    tick();
    tests_run++;
    if (gate !== 4'hB) begin
      tests_failed++;
      $display("FAIL fair_d0_next: gate=%h, want b", gate);
    end
    req  = 4'h0;
    busy = 4'h0;
  endtask

  task automatic test_busy_extend();
    apply_reset();
    req = 4'h4;
    tick();
    req = 4'h0;
    tick();
    tick();
    repeat (15) tick();
    busy = 4'h4;
    tick();
    busy = 4'h0;
    tests_run++;
    if (ready !== 4'h4) begin
      tests_failed++;
      $display("FAIL busy_save: ready=%h, want 4", ready);
    end
    repeat (15) tick();
    tests_run++;
    if (ready !== 4'h4) begin
      tests_failed++;
      $display("FAIL busy_fresh15: ready=%h, want 4", ready);
    end
    tick();
    tests_run++;
    if (gate !== 4'h0 || ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL busy_off: gate=%h ready=%h, want 0/0", gate, ready);
    end
  endtask

  task automatic test_enable_override();
    apply_reset();
    req = 4'h2;
    tick();
    req        = 4'h0;
    enableGate = 1'b0;
    tick();
    tests_run++;
    if (gate !== 4'hF || ready !== 4'hF || wakeActive !== 1'b0) begin
      tests_failed++;
      $display("FAIL force_on: gate=%h ready=%h wake=%b, want f/f/0", gate, ready, wakeActive);
    end
    repeat (20) tick();
    tests_run++;
    if (gate !== 4'hF || ready !== 4'hF) begin
      tests_failed++;
      $display("FAIL force_hold: gate=%h ready=%h, want f/f", gate, ready);
    end
    enableGate = 1'b1;
    repeat (15) tick();
    tests_run++;
    if (gate !== 4'hF) begin
      tests_failed++;
      $display("FAIL resume15: gate=%h, want f", gate);
    end
    tick();
    tests_run++;
    if (gate !== 4'h0 || ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL resume16: gate=%h ready=%h, want 0/0", gate, ready);
    end
  endtask

  task automatic test_reset_mid_wake();
    apply_reset();
    req = 4'h1;
    tick();
    req = 4'h0;
    tests_run++;
    if (wakeActive !== 1'b1 || gate !== 4'h1) begin
      tests_failed++;
      $display("FAIL mid_wake_pre: gate=%h wake=%b, want 1/1", gate, wakeActive);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({gate, ready, wakeActive} !== 9'h0) begin
      tests_failed++;
      $display("FAIL async_reset: gate=%h ready=%h wake=%b, want all 0", gate, ready, wakeActive);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 4'h3;
    tick();
    tests_run++;
    if (gate !== 4'h1 || ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL ptr_after_reset: gate=%h ready=%h, want 1/0", gate, ready);
    end
    req = 4'h0;
    apply_reset();
    req = 4'h2;
    tick();
    req = 4'h0;
    tests_run++;
    if (gate !== 4'h2) begin
      tests_failed++;
      $display("FAIL d1_alone: gate=%h, want 2", gate);
    end
    tick();
    tick();
    tests_run++;
    if (ready !== 4'h2 || wakeActive !== 1'b0) begin
      tests_failed++;
      $display("FAIL d1_ready: ready=%h wake=%b, want 2/0", ready, wakeActive);
    end
  endtask

  initial begin
    test_reset();
    test_single_wake();
    test_round_robin();
    test_fairness();
    test_busy_extend();
    test_enable_override();
    test_reset_mid_wake();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
